// File: rtl/fdiv_sqrt_scheduler_pkg.sv
// Shared FPU definitions for the divide/sqrt scheduler.
// Holds the FSM state enum, recoded-float / rounding-mode / flag widths and
// the packed payloads carried to and from the iterative unit.
package fdiv_sqrt_scheduler_pkg;

    localparam int unsigned REC_W  = 33;  // recoded single-precision width
    localparam int unsigned RM_W   = 3;   // rounding-mode width
    localparam int unsigned FLAG_W = 5;   // exception-flag width
    localparam int unsigned NREQ   = 2;   // number of requesters

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operation presented to the unit on issue
    typedef struct packed {
        logic             sqrt;
        logic [REC_W-1:0] a;
        logic [REC_W-1:0] b;
        logic [RM_W-1:0]  rm;
    } ds_op_t;

    // Result captured from the unit's completion pulse
    typedef struct packed {
        logic [REC_W-1:0]  data;
        logic [FLAG_W-1:0] flags;
    } ds_res_t;

endpackage

// File: rtl/fdiv_sqrt_scheduler_if.sv
// Bundle of the scheduler's request, unit and response-side signals.
// master: the scheduler's view. slave: the surrounding requesters, unit and
// writeback arbiter.
interface fdiv_sqrt_scheduler_if #(
    parameter int unsigned TAG_W = 5
);
    import fdiv_sqrt_scheduler_pkg::*;

    // Requester side
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             req_sqrt;
    logic [NREQ-1:0][REC_W-1:0]  req_a;
    logic [NREQ-1:0][REC_W-1:0]  req_b;
    logic [NREQ-1:0][RM_W-1:0]   req_rm;
    logic [NREQ-1:0][TAG_W-1:0]  req_tag;
    logic                        flush;

    // Divide/sqrt unit side
    logic                        ds_inReady;
    logic                        ds_inValid;
    logic                        ds_sqrtOp;
    logic [REC_W-1:0]            ds_a;
    logic [REC_W-1:0]            ds_b;
    logic [RM_W-1:0]             ds_rm;
    logic                        ds_outValid_div;
    logic                        ds_outValid_sqrt;
    logic [REC_W-1:0]            ds_out;
    logic [FLAG_W-1:0]           ds_flags;

    // Writeback side
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_id;
    logic [TAG_W-1:0]            rsp_tag;
    logic [REC_W-1:0]            rsp_data;
    logic [FLAG_W-1:0]           rsp_flags;
    logic                        err;

    modport master (
        input  req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, flush,
        output req_ready,
        input  ds_inReady, ds_outValid_div, ds_outValid_sqrt, ds_out, ds_flags,
        output ds_inValid, ds_sqrtOp, ds_a, ds_b, ds_rm,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, err
    );

    modport slave (
        output req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, flush,
        input  req_ready,
        output ds_inReady, ds_outValid_div, ds_outValid_sqrt, ds_out, ds_flags,
        input  ds_inValid, ds_sqrtOp, ds_a, ds_b, ds_rm,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_flags, err
    );

endinterface

// File: rtl/fdiv_sqrt_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports: clk, rst_n; en_i allows a grant this cycle; req_i request bits;
// gnt_c_o one-hot grant (combinational); win_c_o index of the winner
// (combinational). The last-granted pointer resets to 1 so requester 0 wins
// the first contention.
module fdiv_sqrt_scheduler_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o,
    output logic       win_c_o
);

    logic last_q;

    // Under contention the requester not granted last wins
    always_comb begin
        win_c_o = (req_i[0] & req_i[1]) ? ~last_q : req_i[1];
        gnt_c_o = 2'b00;
        if (en_i && (|req_i)) begin
            gnt_c_o[win_c_o] = 1'b1;
        end
    end

    // Pointer moves on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (en_i && (|req_i)) begin
            last_q <= win_c_o;
        end
    end

endmodule

// File: rtl/fdiv_sqrt_scheduler.sv
// Arbitration and sequencing controller for the shared iterative divide/sqrt
// unit. Issues one operation at a time from two requesters, tracks owner, tag
// and kind of the op in flight, and buffers the result for writeback.
// Ports: clock, reset_n (async active-low); bus (master modport) carrying
// requests, unit issue/completion, response buffer and sticky err.
// Issue-side outputs (req_ready, ds_*) are combinational by design so the
// request reaches the unit in the same cycle.
module fdiv_sqrt_scheduler
    import fdiv_sqrt_scheduler_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    fdiv_sqrt_scheduler_if.master bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              id_q, id_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              sqrt_q, sqrt_d;
    logic              drop_q, drop_d;
    ds_res_t           res_q, res_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic              arb_en_c;
    logic [1:0]        gnt_c;
    logic              win_c;
    logic              issue_c;
    ds_op_t            op_c;
    logic              pulse_c;
    logic              kind_err_c;

    // Issue only from IDLE with the unit ready and no flush pending
    assign arb_en_c = (state_q == ST_IDLE) & bus.ds_inReady & ~bus.flush;

    fdiv_sqrt_scheduler_rr_arb2 u_arb (
        .clk     (clock),
        .rst_n   (reset_n),
        .en_i    (arb_en_c),
        .req_i   (bus.req_valid),
        .gnt_c_o (gnt_c),
        .win_c_o (win_c)
    );

    assign pulse_c    = bus.ds_outValid_div | bus.ds_outValid_sqrt;
    // Any pulse of the other kind is an error, even alongside the right one
    assign kind_err_c = sqrt_q ? bus.ds_outValid_div : bus.ds_outValid_sqrt;

    // Next-state and issue logic
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        tag_d       = tag_q;
        sqrt_d      = sqrt_q;
        drop_d      = drop_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        issue_c     = 1'b0;
        op_c        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pulse_c) begin
                    err_d = 1'b1;
                end
                if (|gnt_c) begin
                    issue_c     = 1'b1;
                    op_c.sqrt   = bus.req_sqrt[win_c];
                    op_c.a      = bus.req_a[win_c];
                    op_c.b      = bus.req_b[win_c];
                    op_c.rm     = bus.req_rm[win_c];
                    id_d        = win_c;
                    tag_d       = bus.req_tag[win_c];
                    sqrt_d      = bus.req_sqrt[win_c];
                    drop_d      = 1'b0;
                    wdog_d      = '0;
                    state_d     = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (wdog_q != WD_W'(TIMEOUT)) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
                if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                end
                // The unit cannot be aborted; remember to discard its result
                if (bus.flush) begin
                    drop_d = 1'b1;
                end
                if (pulse_c) begin
                    if (kind_err_c) begin
                        err_d = 1'b1;
                    end
                    if (drop_q || bus.flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        res_d.data  = bus.ds_out;
                        res_d.flags = bus.ds_flags;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (pulse_c) begin
                    err_d = 1'b1;
                end
                if (bus.rsp_ready || bus.flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            tag_q       <= '0;
            sqrt_q      <= 1'b0;
            drop_q      <= 1'b0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            tag_q       <= tag_d;
            sqrt_q      <= sqrt_d;
            drop_q      <= drop_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.req_ready  = gnt_c;
    assign bus.ds_inValid = issue_c;
    assign bus.ds_sqrtOp  = op_c.sqrt;
    assign bus.ds_a       = op_c.a;
    assign bus.ds_b       = op_c.b;
    assign bus.ds_rm      = op_c.rm;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_data   = res_q.data;
    assign bus.rsp_flags  = res_q.flags;
    assign bus.err        = err_q;

endmodule
